// File: rtl/mmio_key_switch_responder.sv
//==============================================================================
// Module      : mmio_key_switch_responder
// Description : Memory-mapped KEY/SW input peripheral for the data-memory bus.
//               Two-flop synchronises and debounces KEY[3:0] (active-low pins)
//               and SW[9:0], exposes the clean state in KDATA/SDATA, captures
//               key-press events into sticky write-1-to-clear flags (KEVT) and
//               raises a level interrupt for pending events enabled in KCTRL.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mmio_key_switch_responder #(
   parameter int               DBITS           = 32,
   parameter logic [DBITS-1:0] ADDR_KEY        = 32'hF0000010,
   parameter logic [DBITS-1:0] ADDR_SW         = 32'hF0000014,
   parameter logic [DBITS-1:0] ADDR_KEVT       = 32'hF0000018,
   parameter logic [DBITS-1:0] ADDR_KCTRL      = 32'hF000001C,
   parameter int               DEBOUNCE_CYCLES = 500000,
   parameter int               CNT_BITS        = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [DBITS-1:0] addr,
   input  logic             wrtEn,
   input  logic [DBITS-1:0] dIn,
   input  logic [3:0]       key,
   input  logic [9:0]       sw,
   output logic [DBITS-1:0] dOut,
   output logic             hit,
   output logic             irq
);

   // Keys occupy bits [3:0] of the debounce vector, switches bits [13:4].
   localparam int                 c_NKEYS   = 4;
   localparam int                 c_NSW     = 10;
   localparam int                 c_NBITS   = c_NKEYS + c_NSW;
   localparam logic [CNT_BITS-1:0] c_CNT_MAX = CNT_BITS'(DEBOUNCE_CYCLES - 1);

   // Synchroniser stages
   logic [c_NKEYS-1:0] r_key_s1;
   logic [c_NKEYS-1:0] r_key_s2;
   logic [c_NSW-1:0]   r_sw_s1;
   logic [c_NSW-1:0]   r_sw_s2;

   // Synchronised (keys already inverted to pressed = 1) and debounced vectors
   logic [c_NBITS-1:0] w_sync;
   logic [c_NBITS-1:0] w_deb;
   logic [c_NKEYS-1:0] w_key_nxt;
   logic [c_NKEYS-1:0] w_press;

   // Register state
   logic [c_NKEYS-1:0] r_pend;
   logic [c_NKEYS-1:0] r_ovr;
   logic [c_NKEYS-1:0] r_kctrl;

   // Bus decode
   logic               w_sel_key;
   logic               w_sel_sw;
   logic               w_sel_kevt;
   logic               w_sel_kctrl;
   logic               w_wr_kevt;
   logic               w_wr_kctrl;
   logic [7:0]         w_clr;
   logic [DBITS-1:0]   w_rdata;
   logic               w_unused_din;

   //---------------------------------------------------------------------------
   // Input synchronisation
   //---------------------------------------------------------------------------

   // Two-flop synchronisers; key flops reset to the released (high) pin level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_key_s1 <= '1;
         r_key_s2 <= '1;
         r_sw_s1  <= '0;
         r_sw_s2  <= '0;
      end else begin
         r_key_s1 <= key;
         r_key_s2 <= r_key_s1;
         r_sw_s1  <= sw;
         r_sw_s2  <= r_sw_s1;
      end
   end

   assign w_sync = {r_sw_s2, ~r_key_s2};

   //---------------------------------------------------------------------------
   // Per-bit debounce: a change is accepted only after it has been seen for
   // DEBOUNCE_CYCLES consecutive cycles; any return to the accepted value
   // restarts the count.
   //---------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < c_NBITS; gi++) begin : g_debounce
         logic [CNT_BITS-1:0] r_cnt;
         logic                r_deb;
         logic                w_diff;
         logic                w_done;

         assign w_diff = w_sync[gi] ^ r_deb;
         assign w_done = w_diff && (r_cnt == c_CNT_MAX);

         // Stability counter and accepted value for this input bit.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_cnt <= '0;
               r_deb <= 1'b0;
            end else if (!w_diff) begin
               r_cnt <= '0;
            end else if (w_done) begin
               r_deb <= w_sync[gi];
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end

         assign w_deb[gi] = r_deb;

         // Keys also need the value being accepted this edge for press detect.
         if (gi < c_NKEYS) begin : g_key_next
            assign w_key_nxt[gi] = w_done ? w_sync[gi] : r_deb;
         end
      end
   endgenerate

   // A press is the edge on which a debounced key goes 0 -> 1.
   assign w_press = w_key_nxt & ~w_deb[c_NKEYS-1:0];

   //---------------------------------------------------------------------------
   // Bus decode and register writes
   //---------------------------------------------------------------------------
   assign w_sel_key   = (addr == ADDR_KEY);
   assign w_sel_sw    = (addr == ADDR_SW);
   assign w_sel_kevt  = (addr == ADDR_KEVT);
   assign w_sel_kctrl = (addr == ADDR_KCTRL);
   assign hit         = w_sel_key | w_sel_sw | w_sel_kevt | w_sel_kctrl;

   assign w_wr_kevt   = wrtEn & w_sel_kevt;
   assign w_wr_kctrl  = wrtEn & w_sel_kctrl;
   assign w_clr       = w_wr_kevt ? dIn[7:0] : 8'h00;

   // Only the low byte of store data is meaningful to this block.
   assign w_unused_din = &{1'b0, dIn[DBITS-1:8]};

   // Sticky event flags: the OR with new events after the clear makes a
   // same-cycle hardware set win over a software clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pend <= '0;
         r_ovr  <= '0;
      end else begin
         r_pend <= (r_pend & ~w_clr[3:0]) | w_press;
         r_ovr  <= (r_ovr  & ~w_clr[7:4]) | (w_press & r_pend);
      end
   end

   // Interrupt enable register; bits above [3:0] are not stored.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_kctrl <= '0;
      end else if (w_wr_kctrl) begin
         r_kctrl <= dIn[3:0];
      end
   end

   assign irq = |(r_pend & r_kctrl);

   //---------------------------------------------------------------------------
   // Read mux
   //---------------------------------------------------------------------------

   // Combinational read data, zero when the address misses every register.
   always_comb begin
      w_rdata = '0;
      if (w_sel_key) begin
         w_rdata = {{(DBITS-c_NKEYS){1'b0}}, w_deb[c_NKEYS-1:0]};
      end else if (w_sel_sw) begin
         w_rdata = {{(DBITS-c_NSW){1'b0}}, w_deb[c_NBITS-1:c_NKEYS]};
      end else if (w_sel_kevt) begin
         w_rdata = {{(DBITS-8){1'b0}}, r_ovr, r_pend};
      end else if (w_sel_kctrl) begin
         w_rdata = {{(DBITS-c_NKEYS){1'b0}}, r_kctrl};
      end
   end

   assign dOut = w_rdata;

endmodule

`default_nettype wire

// File: doc/mmio_key_switch_responder.md
Name: mmio_key_switch_responder

Overview:
- Memory-mapped input peripheral on the processor's data-memory bus (second pipeline stage). It answers the processor's loads and stores in the 0xF00000xx I/O window.
- Synchronises and debounces KEY[3:0] and SW[9:0], presents clean state registers and captures key-press events into sticky write-1-to-clear flags.
- Raises a level interrupt request for enabled pending events.
- Its read data and hit flag feed the data-memory output mux.

Parameters:
- DBITS, 32, bus data/address width
- ADDR_KEY, 32'hF0000010, KDATA register address (read-only)
- ADDR_SW, 32'hF0000014, SDATA register address (read-only)
- ADDR_KEVT, 32'hF0000018, KEVT event/overrun register address (W1C)
- ADDR_KCTRL, 32'hF000001C, KCTRL interrupt-enable register address (R/W)
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept an input change (10 ms at 50 MHz); minimum 2
- CNT_BITS, 20, debounce counter width; must hold DEBOUNCE_CYCLES-1

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- addr  input  DBITS  bus address from the pipe register
- wrtEn  input  1  store strobe, sampled on rising clk
- dIn  input  DBITS  store data
- key  input  4  raw KEY pins, active-low (0 = pressed)
- sw  input  10  raw SW pins
- dOut  output  DBITS  read data, combinational from addr
- hit  output  1  addr matches one of the four registers
- irq  output  1  level interrupt request

Behaviour:
- Reset (asynchronous, active-high):
  - Key synchroniser flops reset to 1 (released); switch synchroniser flops reset to 0.
  - All debounce counters reset to 0.
  - KDATA, SDATA, KEVT and KCTRL reset to 0, so irq = 0 during and after reset.
  - Reset asserted mid-debounce discards the partial count.
- Synchronisers:
  - Every raw input passes through 2 flops.
  - Key path is inverted after synchronisation, so pressed = 1.
- Debounce, per input bit (14 independent counters):
  - If the synced value equals the debounced value, the counter clears to 0.
  - Otherwise the counter increments each cycle.
  - On the edge where the counter equals DEBOUNCE_CYCLES-1 and the value still differs, the debounced bit takes the synced value and the counter clears.
  - A synced glitch shorter than DEBOUNCE_CYCLES cycles never changes the debounced bit.
  - Total latency from a pin change to a visible KDATA/SDATA change is 2 + DEBOUNCE_CYCLES edges.
- KDATA: bits[3:0] hold debounced key state; bits[31:4] read 0.
- SDATA: bits[9:0] hold debounced switch state; bits[31:10] read 0.
- KEVT:
  - bits[3:0] PEND[i] set on the edge where debounced key i goes 0->1. A release sets nothing.
  - bits[7:4] OVR[i] set when a press event for key i occurs while PEND[i] is already 1.
  - Other bits read 0.
  - A store to ADDR_KEVT clears each bit where dIn has a 1.
  - If a hardware set and a software clear hit the same bit in the same cycle, the set wins and the bit stays 1.
- KCTRL: bits[3:0] are interrupt enables, read/write; other bits write-ignored and read 0.
- irq = OR over i of (PEND[i] AND KCTRL[i]), registered-free combinational from flops; it drops on the edge after PEND is cleared.
- Stores to ADDR_KEY, ADDR_SW or any unmapped address have no effect.
- Reads have no side effects.
- dOut = selected register when hit = 1, else 0. hit is a pure address compare, independent of wrtEn.
- All state updates occur on the rising clk edge.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset and basic read: assert reset with key=4'hF and sw=0 -> KDATA=0, SDATA=0, KEVT=0, irq=0, hit=0 at addr 0, dOut=0. Then set sw=10'h2A5 -> SDATA reads 0x2A5 exactly 6 edges later.
- Glitch rejection: drive key[1]=0 for 3 cycles (after sync), then back to 1 -> KDATA stays 0 and KEVT stays 0. Next, hold key[1]=0 for 10 cycles -> KDATA=0x2 and KEVT=0x2.
- Interrupt path: write KCTRL=0x2, press key[1] -> irq=1. Store 0x2 to KEVT -> PEND[1]=0 and irq=0 on the following cycle. KCTRL reads back 0x2.
- Overrun: press key[0], release, press again without clearing -> KEVT=0x11. Store 0x10 -> KEVT=0x01.
- Set-wins collision: time a store of 0xF to KEVT on the same edge as key[2]'s debounced press -> KEVT bit2=1 after the edge, while other previously set bits clear.
- Read-only and unmapped stores plus async reset: store 0xFFFFFFFF to ADDR_KEY, ADDR_SW and 0xF0000020 -> no register changes; hit=0 at 0xF0000020. Assert reset mid-debounce (counter=2) -> counter cleared immediately, outputs 0 before the next clk edge.
